// File: rtl/spi_response_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_response_arbiter
// Description : Shares the single SPI peripheral response channel between
//               NUM_REQ requesters. One requester is granted per transaction,
//               and the granted byte is forwarded through a register. Cycles
//               where more than one requester claims the opcode are counted.
//               If no requester answers within TIMEOUT_CYCLES, the arbiter
//               returns DEFAULT_RESPONSE.
//               Optional macro SPI_RESPONSE_ARBITER_ROUND_ROBIN_EN rotates
//               grant priority. Without it, the lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_response_arbiter #(
    parameter int         NUM_REQ          = 4,
    parameter int         TIMEOUT_CYCLES   = 255,
    parameter logic [7:0] DEFAULT_RESPONSE = 8'h00
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [7:0]             opcode_in,
    input  logic                   opcode_valid_in,
    input  logic [8*NUM_REQ-1:0]   response_in,
    input  logic [NUM_REQ-1:0]     response_valid_in,
    output logic [7:0]             response_out,
    output logic                   response_valid_out,
    output logic [2:0]             owner_out,
    output logic                   timeout_out,
    output logic [7:0]             collision_count_out
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_GRANTED   = 2'd2,
        ST_TIMED_OUT = 2'd3
    } state_t;

    localparam logic [15:0] c_timer_last = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  c_count_max  = 8'hFF;

    // Registered state
    state_t      r_state;
    logic        r_opv_d;
    logic [7:0]  r_opcode;
    logic [15:0] r_timer;
    logic [2:0]  r_owner;
    logic [7:0]  r_resp;
    logic        r_resp_valid;
    logic        r_timeout;
    logic [7:0]  r_coll_cnt;

    // Next-state values
    state_t      w_state_nxt;
    logic [7:0]  w_opcode_nxt;
    logic [15:0] w_timer_nxt;
    logic [2:0]  w_owner_nxt;
    logic [7:0]  w_resp_nxt;
    logic        w_resp_valid_nxt;
    logic        w_timeout_nxt;
    logic [7:0]  w_coll_nxt;

    // Arbitration helpers
    logic        w_rise;
    logic        w_any;
    logic        w_multi;
    logic [3:0]  w_num_valid;
    logic [2:0]  w_winner;
    logic [7:0]  w_winner_byte;
    logic        w_owner_valid;
    logic [7:0]  w_owner_byte;

    assign w_rise = opcode_valid_in & ~r_opv_d;
    assign w_any  = |response_valid_in;

    // Count claiming requesters to detect a collision in the grant cycle
    always_comb begin
        w_num_valid = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_num_valid = w_num_valid + {3'd0, response_valid_in[k]};
        end
        w_multi = (w_num_valid > 4'd1);
    end

`ifdef SPI_RESPONSE_ARBITER_ROUND_ROBIN_EN
    logic [2:0] r_last_owner;
    logic [2:0] w_last_owner_nxt;
    logic [2:0] w_search_start;
    logic       w_found;

    assign w_search_start = (r_last_owner == 3'(NUM_REQ - 1)) ? 3'd0 : r_last_owner + 3'd1;

    // Rotating priority: the first pass covers indices at or above the start.
    // The second pass wraps around to the indices below it.
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && response_valid_in[k] && (3'(k) >= w_search_start)) begin
                w_winner = 3'(k);
                w_found  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && response_valid_in[k]) begin
                w_winner = 3'(k);
                w_found  = 1'b1;
            end
        end
    end

    // Last owner advances only on a grant, so a timeout leaves the rotation unchanged
    always_comb begin
        w_last_owner_nxt = r_last_owner;
        if (r_state == ST_WAIT && opcode_valid_in && (opcode_in == r_opcode) && w_any) begin
            w_last_owner_nxt = w_winner;
        end
    end

    // Rotation pointer register
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_last_owner <= 3'(NUM_REQ - 1);
        end else begin
            r_last_owner <= w_last_owner_nxt;
        end
    end
`else
    // Fixed priority: scan downward so the lowest set index wins
    always_comb begin
        w_winner = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (response_valid_in[k]) begin
                w_winner = 3'(k);
            end
        end
    end
`endif

    // Select the byte of the candidate winner and of the current owner
    always_comb begin
        w_winner_byte = 8'd0;
        w_owner_byte  = 8'd0;
        w_owner_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == 3'(k)) begin
                w_winner_byte = response_in[8*k +: 8];
            end
            if (r_owner == 3'(k)) begin
                w_owner_byte  = response_in[8*k +: 8];
                w_owner_valid = response_valid_in[k];
            end
        end
    end

    // Transaction FSM next-state and output logic. A transaction end takes
    // priority over a grant, and a grant takes priority over a timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_opcode_nxt     = r_opcode;
        w_timer_nxt      = r_timer;
        w_owner_nxt      = r_owner;
        w_resp_nxt       = r_resp;
        w_resp_valid_nxt = r_resp_valid;
        w_timeout_nxt    = 1'b0;
        w_coll_nxt       = r_coll_cnt;

        case (r_state)
            ST_IDLE: begin
                w_resp_valid_nxt = 1'b0;
                if (w_rise) begin
                    w_state_nxt  = ST_WAIT;
                    w_opcode_nxt = opcode_in;
                    w_timer_nxt  = 16'd0;
                end
            end
            default: begin
                if (!opcode_valid_in) begin
                    w_state_nxt      = ST_IDLE;
                    w_resp_valid_nxt = 1'b0;
                end else if (opcode_in != r_opcode) begin
                    // A new opcode without a gap starts a new transaction
                    w_state_nxt      = ST_WAIT;
                    w_opcode_nxt     = opcode_in;
                    w_timer_nxt      = 16'd0;
                    w_resp_valid_nxt = 1'b0;
                end else begin
                    case (r_state)
                        ST_WAIT: begin
                            if (w_any) begin
                                w_state_nxt      = ST_GRANTED;
                                w_owner_nxt      = w_winner;
                                w_resp_nxt       = w_winner_byte;
                                w_resp_valid_nxt = 1'b1;
                                if (w_multi && (r_coll_cnt != c_count_max)) begin
                                    w_coll_nxt = r_coll_cnt + 8'd1;
                                end
                            end else if (r_timer == c_timer_last) begin
                                w_state_nxt      = ST_TIMED_OUT;
                                w_resp_nxt       = DEFAULT_RESPONSE;
                                w_resp_valid_nxt = 1'b1;
                                w_timeout_nxt    = 1'b1;
                            end else begin
                                w_timer_nxt = r_timer + 16'd1;
                            end
                        end
                        ST_GRANTED: begin
                            // Only the owner is followed; other requesters are ignored
                            if (w_owner_valid) begin
                                w_resp_nxt       = w_owner_byte;
                                w_resp_valid_nxt = 1'b1;
                            end else begin
                                w_resp_valid_nxt = 1'b0;
                            end
                        end
                        default: begin
                            // In TIMED_OUT, hold the default response until the transaction ends
                        end
                    endcase
                end
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state      <= ST_IDLE;
            r_opcode     <= 8'd0;
            r_timer      <= 16'd0;
            r_owner      <= 3'd0;
            r_resp       <= 8'd0;
            r_resp_valid <= 1'b0;
            r_timeout    <= 1'b0;
            r_coll_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_opcode     <= w_opcode_nxt;
            r_timer      <= w_timer_nxt;
            r_owner      <= w_owner_nxt;
            r_resp       <= w_resp_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_timeout    <= w_timeout_nxt;
            r_coll_cnt   <= w_coll_nxt;
        end
    end

    // Track opcode_valid_in during reset as well. If valid is held high
    // through reset, that is not a fresh rising edge.
    always_ff @(posedge clock_in) begin
        r_opv_d <= opcode_valid_in;
    end

    assign response_out        = r_resp;
    assign response_valid_out  = r_resp_valid;
    assign owner_out           = r_owner;
    assign timeout_out         = r_timeout;
    assign collision_count_out = r_coll_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spi_response_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_response_arbiter
// Description : Scoreboard bench for spi_response_arbiter (NUM_REQ=4,
//               TIMEOUT_CYCLES=8, fixed-priority build). Expected responses
//               are queued as they are stimulated. A monitor pops one entry
//               on each new response_valid_out assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_response_arbiter;

    localparam int c_num_req = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  opcode;
    logic        opv;
    logic [31:0] resp_in;
    logic [3:0]  rvalid;
    logic [7:0]  resp_out;
    logic        resp_valid_out;
    logic [2:0]  owner;
    logic        timeout;
    logic [7:0]  coll_cnt;

    typedef struct packed {
        logic [7:0] resp;
        logic [2:0] owner;
        logic       to;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   to_pulses;

    spi_response_arbiter #(
        .NUM_REQ          (c_num_req),
        .TIMEOUT_CYCLES   (8),
        .DEFAULT_RESPONSE (8'h00)
    ) dut (
        .clock_in            (clk),
        .reset_in            (rst),
        .opcode_in           (opcode),
        .opcode_valid_in     (opv),
        .response_in         (resp_in),
        .response_valid_in   (rvalid),
        .response_out        (resp_out),
        .response_valid_out  (resp_valid_out),
        .owner_out           (owner),
        .timeout_out         (timeout),
        .collision_count_out (coll_cnt)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] b, input logic v);
        resp_in[8*i +: 8] = b;
        rvalid[i]         = v;
    endtask

    task automatic push(input logic [7:0] r, input logic [2:0] o, input logic t, input logic [7:0] c);
        exp_t e;
        e.resp  = r;
        e.owner = o;
        e.to    = t;
        e.cnt   = c;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp"},    16'(resp_out),       16'h0);
        check({tag, "_valid"},   16'(resp_valid_out), 16'h0);
        check({tag, "_owner"},   16'(owner),          16'h0);
        check({tag, "_timeout"}, 16'(timeout),        16'h0);
        check({tag, "_count"},   16'(coll_cnt),       16'h0);
    endtask

    // Stimulus, with the scoreboard monitor forked alongside it
    initial begin
        total     = 0;
        bad       = 0;
        to_pulses = 0;
        rst       = 1'b1;
        opv       = 1'b0;
        opcode    = 8'h00;
        resp_in   = 32'h0;
        rvalid    = 4'h0;

        fork
            begin : monitor
                logic prev_v;
                exp_t e;
                prev_v = 1'b0;
                forever begin
                    @(negedge clk);
                    if (timeout === 1'b1) to_pulses++;
                    if (resp_valid_out === 1'b1 && !prev_v) begin
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sb_unexpected: got resp %0h owner %0d expected no response", resp_out, owner);
                        end else begin
                            e = q.pop_front();
                            check("sb_resp",    16'(resp_out), 16'(e.resp));
                            check("sb_owner",   16'(owner),    16'(e.owner));
                            check("sb_timeout", 16'(timeout),  16'(e.to));
                            check("sb_count",   16'(coll_cnt), 16'(e.cnt));
                        end
                    end
                    prev_v = (resp_valid_out === 1'b1);
                end
            end
        join_none

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single requester 3, valid two cycles after the opcode
        opcode = 8'hDB;
        opv    = 1'b1;
        tick();
        tick();
        set_req(3, 8'h81, 1'b1);
        push(8'h81, 3'd3, 1'b0, 8'd0);
        tick();
        check("t1_owner", 16'(owner), 16'd3);
        tick();
        opv = 1'b0;
        set_req(3, 8'h00, 1'b0);
        tick();
        check("t1_end_valid", 16'(resp_valid_out), 16'd0);
        check("t1_end_hold",  16'(resp_out),       16'h81);
        tick();

        // Owner follow, owner drop, and an ignored re-grant attempt
        opcode = 8'h30;
        opv    = 1'b1;
        set_req(0, 8'h5A, 1'b1);
        push(8'h5A, 3'd0, 1'b0, 8'd0);
        tick();
        tick();
        tick();
        set_req(0, 8'h5B, 1'b1);
        tick();
        check("t5_follow", 16'(resp_out), 16'h5B);
        set_req(0, 8'h5B, 1'b0);
        set_req(1, 8'h11, 1'b1);
        tick();
        check("t5_drop_valid", 16'(resp_valid_out), 16'd0);
        check("t5_drop_hold",  16'(resp_out),       16'h5B);
        tick();
        tick();
        check("t5_no_regrant_valid", 16'(resp_valid_out), 16'd0);
        check("t5_no_regrant_owner", 16'(owner),          16'd0);
        check("t5_count",            16'(coll_cnt),       16'd0);
        opv    = 1'b0;
        rvalid = 4'h0;
        tick();

        // Back-to-back opcode change while owner 0 is granted
        opcode = 8'h20;
        opv    = 1'b1;
        set_req(0, 8'hA0, 1'b1);
        push(8'hA0, 3'd0, 1'b0, 8'd0);
        tick();
        tick();
        tick();
        opcode = 8'h21;
        set_req(0, 8'hA0, 1'b0);
        tick();
        check("t4_newop_valid", 16'(resp_valid_out), 16'd0);
        set_req(2, 8'hC2, 1'b1);
        push(8'hC2, 3'd2, 1'b0, 8'd0);
        tick();
        tick();
        check("t4_owner", 16'(owner), 16'd2);
        opv    = 1'b0;
        rvalid = 4'h0;
        tick();

        // End of transaction coincides with requester valids: no grant, no collision
        opcode = 8'h60;
        opv    = 1'b1;
        tick();
        opv = 1'b0;
        set_req(1, 8'h11, 1'b1);
        set_req(2, 8'h22, 1'b1);
        tick();
        check("simul_end_valid", 16'(resp_valid_out), 16'd0);
        check("simul_end_count", 16'(coll_cnt),       16'd0);
        rvalid = 4'h0;
        tick();

        // Timeout after 8 WAIT cycles with no requester
        opcode = 8'h55;
        opv    = 1'b1;
        push(8'h00, 3'd2, 1'b1, 8'd0);
        tick();
        repeat (7) tick();
        check("t3_before_valid",   16'(resp_valid_out), 16'd0);
        check("t3_before_timeout", 16'(timeout),        16'd0);
        tick();
        check("t3_fire_valid",   16'(resp_valid_out), 16'd1);
        check("t3_fire_timeout", 16'(timeout),        16'd1);
        tick();
        check("t3_pulse_end", 16'(timeout),        16'd0);
        check("t3_hold_resp", 16'(resp_out),       16'h00);
        tick();
        tick();
        check("t3_hold_valid", 16'(resp_valid_out), 16'd1);
        opv = 1'b0;
        tick();
        check("t3_end_valid", 16'(resp_valid_out), 16'd0);

        // Collision between requesters 1 and 2, repeated until the counter saturates
        for (int n = 1; n <= 300; n++) begin
            opcode = 8'h70;
            opv    = 1'b1;
            set_req(1, 8'h11, 1'b1);
            set_req(2, 8'h22, 1'b1);
            push(8'h11, 3'd1, 1'b0, (n > 255) ? 8'd255 : 8'(n));
            tick();
            tick();
            tick();
            opv    = 1'b0;
            rvalid = 4'h0;
            tick();
        end
        check("t2_saturated", 16'(coll_cnt), 16'd255);

        // Reset mid-GRANTED, then no grant until opcode_valid toggles
        opcode = 8'h40;
        opv    = 1'b1;
        set_req(3, 8'h33, 1'b1);
        push(8'h33, 3'd3, 1'b0, 8'd255);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_reset");
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t6_no_grant_valid", 16'(resp_valid_out), 16'd0);
        check("t6_no_grant_owner", 16'(owner),          16'd0);
        opv = 1'b0;
        tick();
        opv = 1'b1;
        push(8'h33, 3'd3, 1'b0, 8'd0);
        tick();
        tick();
        check("t6_regrant_owner", 16'(owner), 16'd3);
        opv    = 1'b0;
        rvalid = 4'h0;
        tick();
        tick();
        tick();

        check("sb_drained",     16'(q.size()),  16'd0);
        check("timeout_pulses", 16'(to_pulses), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
